// File: rtl/gf_add_vec_ctrl.sv
// rtl/gf_add_vec_ctrl.sv - element-wise GF add sequencer over one shared gf_add datapath
// Optional start-while-busy flag o_err is built when GF_ADD_VEC_CTRL_ERR_EN is defined.
module gf_add_vec_ctrl #(
    parameter int WIDTH  = 8,
    parameter int N      = 64,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]  i_rd_data_1,
    input  logic [WIDTH-1:0]  i_rd_data_2,
    output logic              o_add_start,
    output logic [WIDTH-1:0]  o_add_in_1,
    output logic [WIDTH-1:0]  o_add_in_2,
    input  logic [WIDTH-1:0]  i_add_out,
    input  logic              i_add_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data
`ifdef GF_ADD_VEC_CTRL_ERR_EN
    ,
    output logic              o_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // One spare bit so a count of N is distinct from 0 when N == 2^ADDR_W.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(N - 1);
    localparam logic [CW-1:0] N_CNT     = CW'(N);

    state_t            state_q, state_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              in_issue, in_drain;

    assign o_add_in_1 = i_rd_data_1;
    assign o_add_in_2 = i_rd_data_2;
    assign o_wr_data  = i_add_out;
    assign o_wr_addr  = wr_cnt_q[ADDR_W-1:0];
    assign o_add_start = vld_q[RD_LAT-1];

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        in_issue  = (state_q == S_ISSUE);
        in_drain  = (state_q == S_DRAIN);
        o_busy    = (state_q != S_IDLE);
        o_done    = (state_q == S_DONE);
        o_rd_en   = in_issue;
        o_rd_addr = in_issue ? rd_cnt_q[ADDR_W-1:0] : '0;
        // Results arriving outside an active run (e.g. after a reset) are dropped.
        o_wr_en   = i_add_done && (in_issue || in_drain);
        vld_d     = RD_LAT'({vld_q, o_rd_en});

        if (o_wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_ISSUE;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wr_cnt_d == N_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rd_cnt_d = '0;
                wr_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            vld_q    <= vld_d;
        end
    end

`ifdef GF_ADD_VEC_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (i_start) begin
            err_d = (state_q != S_IDLE) ? 1'b1 : 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_gf_add_vec_ctrl.sv
// tb/tb_gf_add_vec_ctrl.sv - directed bench for gf_add_vec_ctrl
// Three instances: N=4/RD_LAT=1, N=1/RD_LAT=2, N=64/RD_LAT=1, each with memory and gf_add models.
module tb_gf_add_vec_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   lat = 2;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: N=4, RD_LAT=1 ----------------
    logic       a_start = 1'b0;
    logic       a_busy, a_done, a_rd_en, a_add_start, a_add_done, a_wr_en;
    logic [1:0] a_rd_addr, a_wr_addr;
    logic [7:0] a_rd1 = 8'h0, a_rd2 = 8'h0, a_in1, a_in2, a_add_out, a_wr_data;
    logic [7:0] a_m1 [4];
    logic [7:0] a_m2 [4];
    logic [7:0] a_exp [4];
    logic       a_p1v = 1'b0, a_p2v = 1'b0;
    logic [7:0] a_p1d = 8'h0, a_p2d = 8'h0;
`ifdef GF_ADD_VEC_CTRL_ERR_EN
    logic       a_err;
`endif

    always @(posedge clk) begin
        if (a_rd_en) begin
            a_rd1 <= a_m1[a_rd_addr];
            a_rd2 <= a_m2[a_rd_addr];
        end
        a_p1v <= a_add_start;
        a_p1d <= a_in1 ^ a_in2;
        a_p2v <= a_p1v;
        a_p2d <= a_p1d;
    end
    assign a_add_done = (lat == 0) ? a_add_start : a_p2v;
    assign a_add_out  = (lat == 0) ? (a_in1 ^ a_in2) : a_p2d;

    gf_add_vec_ctrl #(.WIDTH(8), .N(4), .ADDR_W(2), .RD_LAT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start),
        .o_busy(a_busy), .o_done(a_done), .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr),
        .i_rd_data_1(a_rd1), .i_rd_data_2(a_rd2),
        .o_add_start(a_add_start), .o_add_in_1(a_in1), .o_add_in_2(a_in2),
        .i_add_out(a_add_out), .i_add_done(a_add_done),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data)
`ifdef GF_ADD_VEC_CTRL_ERR_EN
        , .o_err(a_err)
`endif
    );

    // ---------------- instance B: N=1, RD_LAT=2 ----------------
    logic       b_start = 1'b0;
    logic       b_busy, b_done, b_rd_en, b_add_start, b_add_done, b_wr_en;
    logic [0:0] b_rd_addr, b_wr_addr;
    logic [7:0] b_s1 = 8'h0, b_s2 = 8'h0, b_rd1 = 8'h0, b_rd2 = 8'h0;
    logic [7:0] b_in1, b_in2, b_add_out, b_wr_data;
    logic [7:0] b_m1 [2];
    logic [7:0] b_m2 [2];
    logic       b_p1v = 1'b0, b_p2v = 1'b0;
    logic [7:0] b_p1d = 8'h0, b_p2d = 8'h0;
`ifdef GF_ADD_VEC_CTRL_ERR_EN
    logic       b_err;
`endif

    always @(posedge clk) begin
        b_s1  <= b_m1[b_rd_addr];
        b_s2  <= b_m2[b_rd_addr];
        b_rd1 <= b_s1;
        b_rd2 <= b_s2;
        b_p1v <= b_add_start;
        b_p1d <= b_in1 ^ b_in2;
        b_p2v <= b_p1v;
        b_p2d <= b_p1d;
    end
    assign b_add_done = (lat == 0) ? b_add_start : b_p2v;
    assign b_add_out  = (lat == 0) ? (b_in1 ^ b_in2) : b_p2d;

    gf_add_vec_ctrl #(.WIDTH(8), .N(1), .ADDR_W(1), .RD_LAT(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start),
        .o_busy(b_busy), .o_done(b_done), .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr),
        .i_rd_data_1(b_rd1), .i_rd_data_2(b_rd2),
        .o_add_start(b_add_start), .o_add_in_1(b_in1), .o_add_in_2(b_in2),
        .i_add_out(b_add_out), .i_add_done(b_add_done),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data)
`ifdef GF_ADD_VEC_CTRL_ERR_EN
        , .o_err(b_err)
`endif
    );

    // ---------------- instance C: N=64=2^ADDR_W, RD_LAT=1 ----------------
    logic       c_start = 1'b0;
    logic       c_busy, c_done, c_rd_en, c_add_start, c_add_done, c_wr_en;
    logic [5:0] c_rd_addr, c_wr_addr;
    logic [7:0] c_rd1 = 8'h0, c_rd2 = 8'h0, c_in1, c_in2, c_add_out, c_wr_data;
    logic [7:0] c_m1 [64];
    logic [7:0] c_m2 [64];
    logic       c_p1v = 1'b0, c_p2v = 1'b0;
    logic [7:0] c_p1d = 8'h0, c_p2d = 8'h0;
`ifdef GF_ADD_VEC_CTRL_ERR_EN
    logic       c_err;
`endif

    always @(posedge clk) begin
        if (c_rd_en) begin
            c_rd1 <= c_m1[c_rd_addr];
            c_rd2 <= c_m2[c_rd_addr];
        end
        c_p1v <= c_add_start;
        c_p1d <= c_in1 ^ c_in2;
        c_p2v <= c_p1v;
        c_p2d <= c_p1d;
    end
    assign c_add_done = (lat == 0) ? c_add_start : c_p2v;
    assign c_add_out  = (lat == 0) ? (c_in1 ^ c_in2) : c_p2d;

    gf_add_vec_ctrl #(.WIDTH(8), .N(64), .ADDR_W(6), .RD_LAT(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(c_start),
        .o_busy(c_busy), .o_done(c_done), .o_rd_en(c_rd_en), .o_rd_addr(c_rd_addr),
        .i_rd_data_1(c_rd1), .i_rd_data_2(c_rd2),
        .o_add_start(c_add_start), .o_add_in_1(c_in1), .o_add_in_2(c_in2),
        .i_add_out(c_add_out), .i_add_done(c_add_done),
        .o_wr_en(c_wr_en), .o_wr_addr(c_wr_addr), .o_wr_data(c_wr_data)
`ifdef GF_ADD_VEC_CTRL_ERR_EN
        , .o_err(c_err)
`endif
    );

    // Cycle 0 is the cycle in which start is high; dup >= 0 pulses start again mid-run.
    task automatic run_a(input int l, input int dup, input string nm);
        int wbase;
        int dcyc;
        lat   = l;
        wbase = 2 + l;
        dcyc  = 6 + l;
        @(posedge clk);
        #1;
        for (int c = 0; c <= dcyc + 3; c++) begin
            a_start = (c == 0) || (c == dup);
            @(negedge clk);
            check({nm, " busy"}, a_busy, (c >= 1 && c <= dcyc));
            check({nm, " done"}, a_done, (c == dcyc));
            check({nm, " rd_en"}, a_rd_en, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) check({nm, " rd_addr"}, a_rd_addr, c - 1);
            check({nm, " add_start"}, a_add_start, (c >= 2 && c <= 5));
            check({nm, " wr_en"}, a_wr_en, (c >= wbase && c < wbase + 4));
            if (c >= wbase && c < wbase + 4) begin
                check({nm, " wr_addr"}, a_wr_addr, c - wbase);
                check({nm, " wr_data"}, a_wr_data, a_exp[c - wbase]);
            end
`ifdef GF_ADD_VEC_CTRL_ERR_EN
            if (c >= 1) check({nm, " err"}, a_err, (dup >= 0 && c > dup));
`endif
            @(posedge clk);
            #1;
        end
        a_start = 1'b0;
    endtask

    initial begin
        a_m1 = '{8'h01, 8'h02, 8'h03, 8'hFF};
        a_m2 = '{8'h01, 8'hF0, 8'h0C, 8'h0F};
        a_exp = '{8'h00, 8'hF2, 8'h0F, 8'hF0};
        b_m1 = '{8'hA5, 8'h00};
        b_m2 = '{8'h5A, 8'h00};
        for (int i = 0; i < 64; i++) begin
            c_m1[i] = 8'($urandom_range(0, 255));
            c_m2[i] = 8'($urandom_range(0, 255));
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", a_busy, 0);
        check("rst done", a_done, 0);
        check("rst rd_en", a_rd_en, 0);
        check("rst rd_addr", a_rd_addr, 0);
        check("rst add_start", a_add_start, 0);
        check("rst wr_en", a_wr_en, 0);
        check("rst wr_addr", a_wr_addr, 0);
`ifdef GF_ADD_VEC_CTRL_ERR_EN
        check("rst err", a_err, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_a(2, -1, "a_L2");
        run_a(0, -1, "a_L0");
        run_a(2, 3, "a_dup");

        // Reset asserted in cycle 3 of an N=4, L=2 run
        lat = 2;
        @(posedge clk);
        #1;
        for (int c = 0; c <= 8; c++) begin
            a_start = (c == 0);
            if (c == 3) begin
                rst = 1'b1;
                #1;
                check("mid_rst busy", a_busy, 0);
                check("mid_rst done", a_done, 0);
                check("mid_rst rd_en", a_rd_en, 0);
                check("mid_rst rd_addr", a_rd_addr, 0);
                check("mid_rst add_start", a_add_start, 0);
                check("mid_rst wr_en", a_wr_en, 0);
                check("mid_rst wr_addr", a_wr_addr, 0);
            end
            if (c == 4) rst = 1'b0;
            @(negedge clk);
            if (c >= 3) begin
                check("mid_rst no_wr", a_wr_en, 0);
                check("mid_rst idle", a_busy, 0);
                check("mid_rst no_add_start", a_add_start, 0);
            end
            @(posedge clk);
            #1;
        end
        a_start = 1'b0;
        run_a(2, -1, "a_after_rst");

        // N=1, RD_LAT=2, L=2
        lat = 2;
        @(posedge clk);
        #1;
        for (int c = 0; c <= 9; c++) begin
            b_start = (c == 0);
            @(negedge clk);
            check("b busy", b_busy, (c >= 1 && c <= 6));
            check("b done", b_done, (c == 6));
            check("b rd_en", b_rd_en, (c == 1));
            check("b add_start", b_add_start, (c == 3));
            check("b wr_en", b_wr_en, (c == 5));
            if (c == 5) begin
                check("b wr_addr", b_wr_addr, 0);
                check("b wr_data", b_wr_data, 8'hFF);
            end
            @(posedge clk);
            #1;
        end
        b_start = 1'b0;

        // N=64 with random data
        begin
            int n_done;
            int n_wr;
            n_done = 0;
            n_wr = 0;
            lat = 2;
            @(posedge clk);
            #1;
            for (int c = 0; c <= 72; c++) begin
                c_start = (c == 0);
                @(negedge clk);
                if (c_done) n_done++;
                check("c wr_en", c_wr_en, (c >= 4 && c <= 67));
                if (c >= 4 && c <= 67) begin
                    check("c wr_addr", c_wr_addr, c - 4);
                    check("c wr_data", c_wr_data, c_m1[c - 4] ^ c_m2[c - 4]);
                end
                if (c_wr_en) n_wr++;
                if (c == 68) check("c done_cycle", c_done, 1);
                @(posedge clk);
                #1;
            end
            c_start = 1'b0;
            check("c done_count", n_done, 1);
            check("c write_count", n_wr, 64);
            check("c idle_at_end", c_busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gf_add_vec_ctrl.md
# gf_add_vec_ctrl

Sequencer that drives one shared `gf_add` datapath to compute the element-wise GF sum of two N-element vectors held in external synchronous memories. It streams `out[i] = a[i] ^ b[i]` to a result memory and pulses done at the end. It sits between the vector RAMs and a `gf_add` instance, and is the building block for the larger vector/matrix controllers.

## Interface
- `WIDTH`, default 8: element width in bits.
- `N`, default 64: vector length in elements, N ≥ 1.
- `ADDR_W`, default 6: address width; must satisfy 2^ADDR_W ≥ N.
- `RD_LAT`, default 1: read latency of the source memories in cycles, RD_LAT ≥ 1.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  start request; sampled only in IDLE.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  single-cycle completion pulse.
- `o_rd_en`  out  1  read enable to both source memories.
- `o_rd_addr`  out  ADDR_W  read address, shared by both sources.
- `i_rd_data_1`  in  WIDTH  source A data, valid RD_LAT cycles after `o_rd_en`.
- `i_rd_data_2`  in  WIDTH  source B data, valid RD_LAT cycles after `o_rd_en`.
- `o_add_start`  out  1  to `gf_add` `i_start`.
- `o_add_in_1`  out  WIDTH  to `gf_add` `in_1`.
- `o_add_in_2`  out  WIDTH  to `gf_add` `in_2`.
- `i_add_out`  in  WIDTH  from `gf_add` `out`.
- `i_add_done`  in  1  from `gf_add` `o_done`.
- `o_wr_en`  out  1  result memory write enable.
- `o_wr_addr`  out  ADDR_W  result write address.
- `o_wr_data`  out  WIDTH  result write data.
- `o_err`  out  1  start-while-busy flag; present only with the configuration macro.

## Operation
- States and transitions:
  - **IDLE**: on `i_start` → ISSUE.
  - **ISSUE**: `o_rd_en`=1, `o_rd_addr` counts 0..N-1, one element per cycle. After address N-1 → DRAIN.
  - **DRAIN**: waits until N results have been written → DONE.
  - **DONE**: `o_done`=1 for one cycle → IDLE.
- `o_rd_en` feeds an RD_LAT-deep valid shift register. Its output is `o_add_start`.
- `o_add_in_1`/`o_add_in_2` are direct pass-throughs of `i_rd_data_1`/`i_rd_data_2`.
- Write side is driven only by `i_add_done`, so the controller is independent of the `gf_add` REG_IN/REG_OUT setting:
  - `o_wr_en` = `i_add_done` AND (state is ISSUE or DRAIN).
  - `o_wr_data` = `i_add_out`.
  - `o_wr_addr` = write counter, which starts at 0 and increments on each write.
- `i_add_done` in IDLE or DONE is ignored: no write and no count change.
- `i_start` outside IDLE is ignored and never restarts a run.
- Counters are ADDR_W+1 bits wide, so there is no wrap-around ambiguity when N = 2^ADDR_W.
- Reset values: state IDLE; all counters and the valid shift register 0; `o_busy`, `o_done`, `o_rd_en`, `o_rd_addr`, `o_add_start`, `o_wr_en`, `o_wr_addr`, `o_err` all 0. `o_add_in_*` and `o_wr_data` are pass-throughs.
- Reset mid-run:
  - Any run is aborted immediately and the valid shift register is flushed, so no stray `o_add_start` is issued.
  - `gf_add` results still in flight arrive in IDLE and are dropped.

## Timing
- Cycle 0: `i_start` sampled high in IDLE.
- Cycles 1..N: `o_rd_en`=1, with `o_rd_addr` = cycle−1.
- Cycles 1+RD_LAT..N+RD_LAT: `o_add_start`=1.
- With `gf_add` latency L, writes occur on cycles 1+RD_LAT+L..N+RD_LAT+L.
- `o_done` is high on cycle N+RD_LAT+L+1. The next `i_start` is accepted on cycle N+RD_LAT+L+2.
- Throughput: one element per cycle, with no bubbles inside a run.
- N=1 is legal: ISSUE lasts 1 cycle.

## Configuration
- Macro `GF_ADD_VEC_CTRL_ERR_EN`.
  - Defined:
    - `o_err` exists.
    - `o_err` is set sticky when `i_start`=1 in any non-IDLE state.
    - `o_err` is cleared on reset or on the next accepted start.
  - Undefined:
    - The `o_err` port and its logic are absent.
    - Start-while-busy is silently ignored.

## Test plan
- N=4, RD_LAT=1, `gf_add` REG_IN=REG_OUT=1 (L=2), A={01,02,03,FF}, B={01,F0,0C,0F}, start at cycle 0:
  - Writes {00,F2,0F,F0} to addresses 0..3 on cycles 4..7.
  - `o_done` on cycle 8.
  - `o_busy` is high on cycles 1..8.
- Same setup with `gf_add` REG_IN=REG_OUT=0 (L=0): writes on cycles 2..5, `o_done` on cycle 6.
- N=1, RD_LAT=2, A={A5}, B={5A}, L=2: one write of FF to address 0 on cycle 5, `o_done` on cycle 6.
- `i_start` pulsed on cycle 3 of an N=4 run:
  - The run is unaffected and there is no second run.
  - With `GF_ADD_VEC_CTRL_ERR_EN`: `o_err`=1 from cycle 4 until the next accepted start.
- `i_rst` asserted on cycle 3 of an N=4 run (L=2):
  - All outputs are 0 immediately.
  - No `o_wr_en` occurs even though `gf_add` emits done.
  - A fresh start then completes a full N=4 run correctly.
- N=64=2^ADDR_W with random A/B: all 64 results match A^B at addresses 0..63, and `o_done` is issued exactly once.
